// File: rtl/adc_frontend.sv
//==============================================================================
// Module   : adc_frontend
// Purpose  : Capture stage of the equalizer audio path. Clocks a 12-bit serial
//            ADC (AD7476A-style frame: 4 leading zeros, then 12 data bits
//            MSB-first) once per sample period. Each offset-binary code is
//            turned into a signed Q(magn).(decim) sample, and a one-cycle
//            strobe is issued alongside it for the band-pass filter bank.
// Ports    : clock      - system clock, rising edge
//            reset      - asynchronous, active-high
//            enable     - run control; frames start only while high
//            adc_sdata  - ADC serial data in
//            adc_cs_n   - ADC chip select, active-low (registered)
//            adc_sclk   - ADC serial clock, idles high (registered)
//            gen_enable - one-cycle new-sample strobe (registered)
//            DataOut    - signed output sample, N bits (registered)
//            err_count  - saturating count of rejected frames (registered)
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module adc_frontend #(
    parameter int decim      = 14,
    parameter int magn       = 8,
    parameter int N          = decim + magn + 1,
    parameter int ADC_BITS   = 12,
    parameter int CLK_DIV    = 4,
    parameter int SAMPLE_DIV = 2268
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         enable,
    input  logic         adc_sdata,
    output logic         adc_cs_n,
    output logic         adc_sclk,
    output logic         gen_enable,
    output logic [N-1:0] DataOut,
    output logic [7:0]   err_count
);

    localparam int c_FRAME_BITS = 16;
    localparam int c_SHIFT      = decim - ADC_BITS + 1;
    localparam int c_CNT_W      = $clog2(SAMPLE_DIV);
    localparam int c_DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int c_BITS_W     = 5;

    localparam logic [c_CNT_W-1:0]  c_CNT_MAX  = c_CNT_W'(SAMPLE_DIV - 1);
    localparam logic [c_DIV_W-1:0]  c_DIV_MAX  = c_DIV_W'(CLK_DIV - 1);
    localparam logic [c_BITS_W-1:0] c_LAST_BIT = c_BITS_W'(c_FRAME_BITS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_LOW   = 2'd2,
        S_HIGH  = 2'd3
    } state_t;

    state_t                 r_state;
    logic [c_CNT_W-1:0]     r_cnt;
    logic [c_DIV_W-1:0]     r_div;
    logic [c_BITS_W-1:0]    r_bits;
    logic [c_FRAME_BITS-1:0] r_shift;

    logic                   w_start;
    logic                   w_div_last;
    logic                   w_frame_ok;
    logic [ADC_BITS-1:0]    w_code;
    logic [ADC_BITS-1:0]    w_twos;
    logic signed [N-1:0]    w_ext;
    logic [N-1:0]           w_sample;

    //--------------------------------------------------------------------------
    // Sample-period counter: free-runs 0..SAMPLE_DIV-1 while enabled and is
    // held at zero otherwise, so re-enabling starts a frame on the very first
    // edge that sees enable high.
    //--------------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (!enable) begin
            r_cnt <= '0;
        end else if (r_cnt == c_CNT_MAX) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign w_start    = enable && (r_cnt == '0) && (r_state == S_IDLE);
    assign w_div_last = (r_div == c_DIV_MAX);

    // Leading bits of a good frame are always zero; anything else means the
    // serial link slipped and the word is discarded.
    assign w_frame_ok = (r_shift[c_FRAME_BITS-1:ADC_BITS] == '0);
    assign w_code     = r_shift[ADC_BITS-1:0];

    // Offset binary to two's complement is just an MSB flip (code - 2048).
    assign w_twos     = {~w_code[ADC_BITS-1], w_code[ADC_BITS-2:0]};
    assign w_ext      = N'($signed(w_twos));
    assign w_sample   = w_ext <<< c_SHIFT;

    //--------------------------------------------------------------------------
    // Frame sequencer. The ADC shifts its data out on sclk falling edges, so
    // each bit is stable for a full half-period before we capture it on the
    // edge that raises sclk; since sclk is our own register, adc_sdata is
    // synchronous to this clock and needs no resynchroniser.
    //--------------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_div      <= '0;
            r_bits     <= '0;
            r_shift    <= '0;
            adc_cs_n   <= 1'b1;
            adc_sclk   <= 1'b1;
            gen_enable <= 1'b0;
            DataOut    <= '0;
            err_count  <= '0;
        end else begin
            gen_enable <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        adc_cs_n <= 1'b0;
                        r_div    <= '0;
                        r_bits   <= '0;
                        r_state  <= S_SETUP;
                    end
                end

                S_SETUP: begin
                    if (w_div_last) begin
                        r_div    <= '0;
                        adc_sclk <= 1'b0;
                        r_state  <= S_LOW;
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end

                S_LOW: begin
                    if (w_div_last) begin
                        r_div    <= '0;
                        adc_sclk <= 1'b1;
                        r_shift  <= {r_shift[c_FRAME_BITS-2:0], adc_sdata};
                        r_bits   <= r_bits + 1'b1;
                        r_state  <= S_HIGH;
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end

                S_HIGH: begin
                    if (w_div_last) begin
                        r_div <= '0;
                        if (r_bits == c_LAST_BIT) begin
                            adc_cs_n <= 1'b1;
                            r_state  <= S_IDLE;
                            if (w_frame_ok) begin
                                DataOut    <= w_sample;
                                gen_enable <= 1'b1;
                            end else if (err_count != 8'hFF) begin
                                err_count <= err_count + 1'b1;
                            end
                        end else begin
                            adc_sclk <= 1'b0;
                            r_state  <= S_LOW;
                        end
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end

                default: begin
                    r_state  <= S_IDLE;
                    adc_cs_n <= 1'b1;
                    adc_sclk <= 1'b1;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_adc_frontend.sv
//==============================================================================
// Module   : tb_adc_frontend
// Purpose  : Self-checking bench for adc_frontend. A behavioural ADC model
//            serves 16-bit frame words; expected samples, error counts and
//            strobe timing come from plain arithmetic on those words.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_adc_frontend;

    localparam int DECIM = 14;
    localparam int MAGN  = 8;
    localparam int NW    = DECIM + MAGN + 1;
    localparam int ADCB  = 12;
    localparam int CDIV  = 4;
    localparam int SDIV  = 200;
    localparam int SCALE = 1 << (DECIM - ADCB + 1);

    typedef logic [NW-1:0] samp_t;

    logic        clock     = 1'b0;
    logic        reset     = 1'b0;
    logic        enable    = 1'b0;
    logic        adc_sdata = 1'b0;
    logic        adc_cs_n;
    logic        adc_sclk;
    logic        gen_enable;
    samp_t       DataOut;
    logic [7:0]  err_count;

    int total   = 0;
    int bad     = 0;
    int cyc     = 0;
    int strobes = 0;

    // frame bookkeeping
    int    lowcnt;
    int    rises;
    logic  prev_sclk;
    samp_t exp_data  = '0;
    int    exp_err   = 0;
    int    last_cyc  = 0;
    bit    have_last = 0;

    adc_frontend #(
        .decim      (DECIM),
        .magn       (MAGN),
        .N          (NW),
        .ADC_BITS   (ADCB),
        .CLK_DIV    (CDIV),
        .SAMPLE_DIV (SDIV)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .adc_sdata  (adc_sdata),
        .adc_cs_n   (adc_cs_n),
        .adc_sclk   (adc_sclk),
        .gen_enable (gen_enable),
        .DataOut    (DataOut),
        .err_count  (err_count)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) if (gen_enable === 1'b1) strobes <= strobes + 1;

    // ADC model: word latched when cs_n falls, one bit presented per sclk fall.
    logic [15:0] adc_word = 16'h0800;
    logic [15:0] adc_sh   = '0;
    int          adc_idx  = 15;
    logic        prev_cs  = 1'b1;
    logic        prev_sck = 1'b1;
    always @(negedge clock) begin
        if (prev_cs && !adc_cs_n) begin
            adc_sh  = adc_word;
            adc_idx = 15;
        end
        if (prev_sck && !adc_sclk && !adc_cs_n && adc_idx >= 0) begin
            adc_sdata = adc_sh[adc_idx];
            adc_idx--;
        end
        prev_cs  = adc_cs_n;
        prev_sck = adc_sclk;
    end

    function automatic samp_t model_out(input logic [15:0] w);
        int s;
        s = int'(w[11:0]) - 2048;
        return samp_t'(s * SCALE);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cs_low(output bit ok);
        ok = 0;
        for (int i = 0; i < SDIV + 20; i++) begin
            @(posedge clock); #1;
            if (adc_cs_n === 1'b0) begin
                ok = 1;
                break;
            end
        end
        lowcnt    = 1;
        rises     = 0;
        prev_sclk = adc_sclk;
    endtask

    task automatic finish_frame(input int drop_at, output bit ok);
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clock); #1;
            if (adc_cs_n === 1'b1) begin
                ok = 1;
                break;
            end
            lowcnt++;
            if (!prev_sclk && adc_sclk) rises++;
            prev_sclk = adc_sclk;
            if (lowcnt == drop_at) enable = 1'b0;
        end
    endtask

    task automatic check_frame(input string tag, input logic [15:0] word,
                               input bit chk_int, input int snap);
        bit valid;
        valid = (word[15:12] == 4'h0);
        if (valid) exp_data = model_out(word);
        else if (exp_err < 255) exp_err++;
        check({tag, ".cs_low"},  lowcnt, 33 * CDIV);
        check({tag, ".rises"},   rises, 16);
        check({tag, ".strobe"},  gen_enable, valid);
        check({tag, ".data"},    DataOut, exp_data);
        check({tag, ".err"},     err_count, exp_err);
        if (valid && chk_int && have_last)
            check({tag, ".interval"}, cyc - last_cyc, SDIV);
        if (valid) begin
            last_cyc  = cyc;
            have_last = 1;
        end
        @(posedge clock); #1;
        check({tag, ".strobe_clr"}, gen_enable, 0);
        check({tag, ".strobe_cnt"}, strobes - snap, valid);
    endtask

    task automatic run_frame(input string tag, input logic [15:0] word,
                             input bit chk_int, input int drop_at);
        bit ok;
        int snap;
        adc_word = word;
        snap     = strobes;
        wait_cs_low(ok);
        check({tag, ".start"}, ok, 1);
        finish_frame(drop_at, ok);
        check({tag, ".end"}, ok, 1);
        check_frame(tag, word, chk_int, snap);
    endtask

    initial begin
        bit          ok;
        int          snap;
        int          low_seen;
        logic [15:0] w;

        // reset values
        #1 reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check("rst.cs_n", adc_cs_n, 1);
        check("rst.sclk", adc_sclk, 1);
        check("rst.gen",  gen_enable, 0);
        check("rst.data", DataOut, 0);
        check("rst.err",  err_count, 0);
        reset = 1'b0;
        @(posedge clock); #1;
        enable = 1'b1;

        // mid-scale, then the directed code sequence
        run_frame("mid", 16'h0800, 1, -1);
        check("mid.lit", DataOut, 23'h000000);
        run_frame("fs_pos", 16'h0FFF, 1, -1);
        check("fs_pos.lit", DataOut, 23'h003FF8);
        run_frame("fs_neg", 16'h0000, 1, -1);
        check("fs_neg.lit", DataOut, 23'h7FC000);
        run_frame("mid1", 16'h0801, 1, -1);
        check("mid1.lit", DataOut, 23'h000008);

        // random valid codes
        for (int i = 0; i < 6; i++) begin
            w = 16'($urandom_range(0, 4095));
            run_frame("rnd", w, 1, -1);
        end

        // rejected frames: single directed one, then saturation
        run_frame("bad0", 16'h1ABC, 0, -1);
        check("bad0.err_lit", err_count, 1);
        for (int i = 0; i < 255; i++) begin
            w = 16'(($urandom_range(1, 15) << 12) | $urandom_range(0, 4095));
            run_frame("badn", w, 0, -1);
        end
        check("sat.err_lit", err_count, 255);

        // one more good frame to re-establish strobe spacing
        run_frame("rearm", 16'($urandom_range(0, 4095)), 0, -1);

        // enable dropped 40 clocks into a frame
        run_frame("drop", 16'h0123, 1, 40);
        low_seen = 0;
        for (int i = 0; i < 3 * SDIV; i++) begin
            @(posedge clock); #1;
            if (adc_cs_n !== 1'b1) low_seen++;
        end
        check("drop.idle", low_seen, 0);

        // re-enable: cs_n must fall on the first edge that samples enable=1
        w        = 16'h0ABC;
        adc_word = w;
        snap     = strobes;
        enable   = 1'b1;
        @(posedge clock); #1;
        check("reen.cs_fall", adc_cs_n, 0);
        lowcnt    = 1;
        rises     = 0;
        prev_sclk = adc_sclk;
        finish_frame(-1, ok);
        check("reen.end", ok, 1);
        check_frame("reen", w, 0, snap);

        // reset in the middle of shifting
        adc_word = 16'h0FFF;
        snap     = strobes;
        wait_cs_low(ok);
        check("rstmid.start", ok, 1);
        repeat (50) @(posedge clock);
        #3 reset = 1'b1;
        #1;
        check("rstmid.cs_n", adc_cs_n, 1);
        check("rstmid.sclk", adc_sclk, 1);
        check("rstmid.data", DataOut, 0);
        check("rstmid.err",  err_count, 0);
        repeat (5) @(posedge clock);
        #1;
        check("rstmid.no_strobe", strobes - snap, 0);
        check("rstmid.cs_hold",   adc_cs_n, 1);
        enable = 1'b0;
        reset  = 1'b0;
        repeat (3) @(posedge clock);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
